accumulator_alu: RTL and testbench

ACCUMULATOR_ALU -- requirements
Module: accumulator_alu

---
 rtl/accumulator_alu.sv | 122 ++++++++++++
 tb/tb_accumulator_alu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/accumulator_alu.sv
// Accumulator A, operand register B, output register and flag register
// around an add/subtract ALU sitting on a shared single-bus datapath.
module accumulator_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             la,
    input  logic             lb,
    input  logic             ea,
    input  logic             eu,
    input  logic             su,
    input  logic             inc,
    input  logic             dec,
    input  logic             lo,
    input  logic             hlt,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       flagReg,
    output logic             conflict
);

    localparam int unsigned RW = WIDTH + 1;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   alu_res;
    logic [WIDTH-1:0] a_plus;
    logic [WIDTH-1:0] a_minus;
    logic             do_inc;
    logic             do_dec;
    logic             flag_we;
    logic [1:0]       flag_nxt;
    logic             bad_ctrl;

    // Subtraction is A + ~B + 1, so carry-out doubles as "no borrow"
    assign alu_res = {1'b0, a} + {1'b0, (su ? ~b : b)} + RW'(su);
    assign a_plus  = a + WIDTH'(1);
    assign a_minus = a - WIDTH'(1);

    // In-place inc/dec only when unambiguous and not overridden by a load
    assign do_inc   = inc & ~dec & ~la;
    assign do_dec   = dec & ~inc & ~la;
    assign bad_ctrl = (eu & ea) | (inc & dec) | (la & (inc | dec));

    // Flag source select: inc/dec outranks an ALU commit on the same edge
    always_comb begin
        flag_we  = 1'b0;
        flag_nxt = flagReg;
        if (do_inc) begin
            flag_we  = 1'b1;
            flag_nxt = {(a == '1), (a_plus == '0)};
        end else if (do_dec) begin
            flag_we  = 1'b1;
            flag_nxt = {(a != '0), (a_minus == '0)};
        end else if (eu) begin
            flag_we  = 1'b1;
            flag_nxt = {alu_res[WIDTH], (alu_res[WIDTH-1:0] == '0)};
        end
    end

    // Bus driver: ALU result has priority over the accumulator
    always_comb begin
        bus_out   = '0;
        bus_drive = 1'b0;
        if (eu) begin
            bus_out   = alu_res[WIDTH-1:0];
            bus_drive = 1'b1;
        end else if (ea) begin
            bus_out   = a;
            bus_drive = 1'b1;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
        end else if (!hlt) begin
            if (la) begin
                a <= bus_in;
            end else if (do_inc) begin
                a <= a_plus;
            end else if (do_dec) begin
                a <= a_minus;
            end
        end
    end

    // B operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b        <= '0;
            out_data <= '0;
        end else if (!hlt) begin
            if (lb) begin
                b <= bus_in;
            end
            if (lo) begin
                out_data <= bus_in;
            end
        end
    end

    // Flags and sticky illegal-control indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flagReg  <= 2'b00;
            conflict <= 1'b0;
        end else if (!hlt) begin
            if (flag_we) begin
                flagReg <= flag_nxt;
            end
            if (bad_ctrl) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_alu.sv
// Self-checking bench for accumulator_alu: vector table plus scoreboard queue.
module tb_accumulator_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = '0;
    logic       la = 0, lb = 0, ea = 0, eu = 0, su = 0, inc = 0, dec = 0, lo = 0, hlt = 0;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [7:0] out_data;
    logic [1:0] flagReg;
    logic       conflict;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       la, lb, ea, eu, su, inc, dec, lo, hlt;
        logic [7:0] bin;
        logic [7:0] xbus;
        logic       xdrv;
        logic [7:0] xa;
        logic [1:0] xf;
        logic       xc;
        logic [7:0] xo;
    } vec_t;

    typedef struct packed {
        logic [7:0] xa;
        logic [1:0] xf;
        logic       xc;
        logic [7:0] xo;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[22];

    accumulator_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .la(la), .lb(lb), .ea(ea), .eu(eu), .su(su),
        .inc(inc), .dec(dec), .lo(lo), .hlt(hlt),
        .bus_out(bus_out), .bus_drive(bus_drive), .out_data(out_data),
        .flagReg(flagReg), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_ctrl();
        la = 0; lb = 0; ea = 0; eu = 0; su = 0; inc = 0; dec = 0; lo = 0; hlt = 0;
    endtask

    // Drive one vector, check same-cycle bus, then check registered state after the edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        {la, lb, ea, eu, su, inc, dec, lo, hlt} = {v.la, v.lb, v.ea, v.eu, v.su, v.inc, v.dec, v.lo, v.hlt};
        bus_in = v.bin;
        #1;
        chk($sformatf("v%0d bus_out", idx), 32'(bus_out), 32'(v.xbus));
        chk($sformatf("v%0d bus_drive", idx), 32'(bus_drive), 32'(v.xdrv));
        sb.push_back('{xa: v.xa, xf: v.xf, xc: v.xc, xo: v.xo});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d out_data", idx), 32'(out_data), 32'(e.xo));
            chk($sformatf("v%0d flagReg", idx), 32'(flagReg), 32'(e.xf));
            chk($sformatf("v%0d conflict", idx), 32'(conflict), 32'(e.xc));
            clear_ctrl();
            ea = 1;
            #1;
            chk($sformatf("v%0d A", idx), 32'(bus_out), 32'(e.xa));
            ea = 0;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        clear_ctrl();
        rst = 1;
        #2;
        rst = 0;
    endtask

    initial begin
        //          la lb ea eu su in de lo hl  bin    xbus   xd  xa     xf     xc  xo
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h05, 8'h00, 0, 8'h05, 2'b00, 0, 8'h00};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h00, 0, 8'h05, 2'b00, 0, 8'h00};
        vecs[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h08, 8'h08, 1, 8'h08, 2'b00, 0, 8'h00};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h00, 0, 8'h03, 2'b00, 0, 8'h00};
        vecs[4]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 2'b11, 0, 8'h00};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h02, 8'h00, 0, 8'h02, 2'b11, 0, 8'h00};
        vecs[6]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 8'hFF, 2'b00, 0, 8'h00};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b11, 0, 8'h00};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 2'b00, 0, 8'h00};
        vecs[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 8'hFF, 2'b00, 0, 8'h00};
        vecs[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h02, 1, 8'hFF, 2'b10, 0, 8'h00};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h5A, 8'h00, 0, 8'hFF, 2'b10, 0, 8'h5A};
        vecs[12] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h02, 1, 8'h00, 2'b11, 0, 8'h5A};
        vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 0, 8'h10, 2'b11, 0, 8'h5A};
        vecs[14] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00, 8'h0D, 1, 8'h0F, 2'b10, 0, 8'h5A};
        vecs[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h10, 8'h00, 0, 8'h10, 2'b10, 0, 8'h5A};
        vecs[16] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h10, 2'b10, 1, 8'h5A};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h10, 2'b10, 1, 8'h5A};
        vecs[18] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h13, 1, 8'h10, 2'b00, 1, 8'h5A};
        vecs[19] = '{1, 1, 0, 0, 0, 1, 0, 1, 1, 8'h77, 8'h00, 0, 8'h10, 2'b00, 1, 8'h5A};
        vecs[20] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h10, 1, 8'h10, 2'b00, 1, 8'h5A};
        vecs[21] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h0D, 1, 8'h10, 2'b10, 1, 8'h5A};

        // Reset state while rst is held
        #2;
        chk("rst out_data", 32'(out_data), 32'h00);
        chk("rst flagReg", 32'(flagReg), 32'h0);
        chk("rst conflict", 32'(conflict), 32'h0);
        chk("rst bus_out", 32'(bus_out), 32'h00);
        chk("rst bus_drive", 32'(bus_drive), 32'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i], i);
        end

        // Load output register, then reset mid-cycle with a pending load
        apply('{0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h2A, 8'h00, 0, 8'h10, 2'b10, 1, 8'h2A}, 100);
        @(negedge clk);
        la = 1; lo = 1; bus_in = 8'h66;
        #2;
        rst = 1;
        #1;
        chk("midrst out_data", 32'(out_data), 32'h00);
        chk("midrst flagReg", 32'(flagReg), 32'h0);
        chk("midrst conflict", 32'(conflict), 32'h0);
        @(posedge clk);
        #1;
        chk("rsthold out_data", 32'(out_data), 32'h00);
        @(negedge clk);
        clear_ctrl();
        rst = 0;
        ea = 1;
        #1;
        chk("rsthold A", 32'(bus_out), 32'h00);
        ea = 0;

        // First post-reset edge: la with inc loads A and flags conflict
        apply('{1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h21, 8'h00, 0, 8'h21, 2'b00, 1, 8'h00}, 101);

        // eu with ea from reset state: ALU 0+0 commits Z, flags conflict
        pulse_rst();
        #1;
        chk("rst2 conflict", 32'(conflict), 32'h0);
        apply('{0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 2'b01, 1, 8'h00}, 102);

        // Decrement wrap from reset state
        pulse_rst();
        apply('{0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 2'b00, 0, 8'h00}, 103);
        apply('{0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b11, 0, 8'h00}, 104);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
